// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - register map, STATUS bit positions and FSM states for mmio_uart_tx
package mmio_uart_pkg;
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_IE     = 2'd3;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;
endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// rtl/mmio_uart_tx_sync_fifo.sv - synchronous FIFO with occupancy count; pushes while full are dropped
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// MMIO_UART_IRQ_EN adds the irq output and the IE register at word 3.
module mmio_uart_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        re,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
`ifdef MMIO_UART_IRQ_EN
    output logic        irq,
`endif
    output logic        tx
);
    import mmio_uart_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            push_req, ovf_clr, start_frame, busy, timer_done, ovf;
    logic            fifo_full, fifo_empty;
    logic [7:0]      fifo_dout, shift;
    logic [CW-1:0]   fifo_count;
    logic [15:0]     div_reg, div_eff, div_lat, timer;
    logic [2:0]      bit_cnt;
    logic [31:0]     status_word;
    logic            unused_ok;
    uart_state_t     state;
`ifdef MMIO_UART_IRQ_EN
    logic [1:0]      ie;
`endif

    assign push_req   = sel & we[0] & (addr == ADDR_DATA);
    assign ovf_clr    = sel & we[0] & (addr == ADDR_STATUS) & wdata[3];
    assign busy       = (state != S_IDLE);
    assign timer_done = (timer == 16'd0);
    assign div_eff    = (div_reg == 16'd0) ? 16'd1 : div_reg;
    // A frame starts from idle or straight out of a finished stop bit, so queued frames butt together.
    assign start_frame = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && timer_done));
    assign unused_ok   = &{1'b0, we[3:2], wdata[31:16]};

    always_comb begin
        status_word                          = '0;
        status_word[ST_FULL]                 = fifo_full;
        status_word[ST_EMPTY]                = fifo_empty;
        status_word[ST_BUSY]                 = busy;
        status_word[ST_OVF]                  = ovf;
        status_word[ST_COUNT_LSB+3:ST_COUNT_LSB] = 4'(fifo_count);
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (start_frame),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= 16'(DIV_RESET);
            ovf     <= 1'b0;
`ifdef MMIO_UART_IRQ_EN
            ie      <= 2'b00;
`endif
        end else begin
            if (sel && addr == ADDR_DIV && we[0]) div_reg[7:0]  <= wdata[7:0];
            if (sel && addr == ADDR_DIV && we[1]) div_reg[15:8] <= wdata[15:8];
            if (push_req && fifo_full) ovf <= 1'b1;
            else if (ovf_clr)          ovf <= 1'b0;
`ifdef MMIO_UART_IRQ_EN
            if (sel && addr == ADDR_IE && we[0]) ie <= wdata[1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (sel && re) begin
            case (addr)
                ADDR_STATUS: rdata <= status_word;
                ADDR_DIV:    rdata <= {16'd0, div_reg};
`ifdef MMIO_UART_IRQ_EN
                ADDR_IE:     rdata <= {30'd0, ie};
`endif
                default:     rdata <= '0;
            endcase
        end
    end

`ifdef MMIO_UART_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else        irq <= (ie[0] & fifo_empty & ~busy) | (ie[1] & ovf);
    end
`endif

    // Divisor is latched per frame; timer counts div-1 down to 0 for each bit slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            shift   <= 8'd0;
            bit_cnt <= 3'd0;
            timer   <= 16'd0;
            div_lat <= 16'd1;
        end else if (start_frame) begin
            state   <= S_START;
            tx      <= 1'b0;
            shift   <= fifo_dout;
            bit_cnt <= 3'd0;
            timer   <= div_eff - 16'd1;
            div_lat <= div_eff;
        end else begin
            case (state)
                S_START: begin
                    if (timer_done) begin
                        state <= S_DATA;
                        tx    <= shift[0];
                        timer <= div_lat - 16'd1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_DATA: begin
                    if (timer_done) begin
                        timer <= div_lat - 16'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_STOP: begin
                    if (timer_done) begin
                        state <= S_IDLE;
                        tx    <= 1'b1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: tx <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench for mmio_uart_tx (optionally with MMIO_UART_IRQ_EN)
module tb_mmio_uart_tx;
    import mmio_uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    logic        clk, reset, sel, re, tx;
    logic [1:0]  addr;
    logic [3:0]  we;
    logic [31:0] wdata, rdata;
`ifdef MMIO_UART_IRQ_EN
    logic        irq;
    logic        irq_q = 1'b0;
    int          irq_rise_cyc = -1;
`endif

    int     checks = 0;
    int     failures = 0;
    frame_t sb[$];
    int     starts[$];
    int     cnt_seq[$];
    int     cyc = 0;
    int     frames_done = 0;
    int     last_end = 0;
    bit     m_active = 0;
    bit     bit_ok = 1;
    int     m_cyc = 0;
    int     bidx;
    logic   expb;
    frame_t cur;

    mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(104)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .re    (re),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
`ifdef MMIO_UART_IRQ_EN
        .irq   (irq),
`endif
        .tx    (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Serial line monitor: pops the expected frame at each start bit and checks every bit slot.
    always @(negedge clk) begin
        cyc++;
`ifdef MMIO_UART_IRQ_EN
        if (irq === 1'b1 && irq_q !== 1'b1 && irq_rise_cyc < 0) irq_rise_cyc = cyc;
        irq_q = irq;
`endif
        if (reset !== 1'b1) begin
            m_active = 0;
        end else begin
            if (!m_active && tx === 1'b0) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_frame observed=start_bit expected=idle cyc=%0d", cyc);
                end
                if (sb.size() != 0) cur = sb.pop_front();
                else cur = '{data: 8'h00, div: 1};
                m_active = 1;
                m_cyc = 0;
                bit_ok = 1;
                starts.push_back(cyc);
            end
            if (m_active) begin
                bidx = m_cyc / cur.div;
                expb = (bidx == 0) ? 1'b0 : (bidx == 9) ? 1'b1 : cur.data[bidx-1];
                if (tx !== expb) bit_ok = 0;
                if ((m_cyc % cur.div) == cur.div - 1) begin
                    checks++;
                    assert (bit_ok) else begin
                        failures++;
                        $error("FAIL frame_bit byte=%h slot=%0d observed=%b expected=%b", cur.data, bidx, tx, expb);
                    end
                    bit_ok = 1;
                end
                m_cyc++;
                if (m_cyc == 10 * cur.div) begin
                    m_active = 0;
                    frames_done++;
                    last_end = cyc;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic bus_write(input logic s, input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
        sel = s; addr = a; we = w; wdata = d; re = 1'b0;
        @(posedge clk);
        #2;
        sel = 1'b0; we = 4'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; re = 1'b1; addr = a; we = 4'h0;
        @(posedge clk);
        #2;
        sel = 1'b0; re = 1'b0;
        d = rdata;
    endtask

    task automatic send(input logic [7:0] b, input int div);
        sb.push_back('{data: b, div: div});
        bus_write(1'b1, ADDR_DATA, 4'b0001, {24'h0, b});
    endtask

    // Reads STATUS every cycle until busy has been seen and then drops, or the budget runs out.
    task automatic poll_status(input int max_cyc, output int busy_cnt, output logic [31:0] last, output bit timeout);
        bit seen;
        seen = 0; busy_cnt = 0; timeout = 1; last = '0;
        cnt_seq.delete();
        sel = 1'b1; re = 1'b1; addr = ADDR_STATUS; we = 4'h0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #2;
            last = rdata;
            if (cnt_seq.size() == 0 || cnt_seq[cnt_seq.size()-1] != int'(rdata[11:8]))
                cnt_seq.push_back(int'(rdata[11:8]));
            if (rdata[2]) begin
                seen = 1;
                busy_cnt++;
            end else if (seen) begin
                timeout = 0;
                break;
            end
        end
        sel = 1'b0; re = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int          bc;
        bit          to;
        int          base;
        logic [31:0] seq_word;

        reset = 1'b0; sel = 1'b0; re = 1'b0; addr = 2'd0; we = 4'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_rdata", rdata, 32'd0);
        reset = 1'b1;
        idle(1);

        bus_read(ADDR_STATUS, d);
        check("status_empty_read", d, 32'h2);
        bus_read(ADDR_DIV, d);
        check("div_reset", d, 32'd104);
        idle(2);
        check("rdata_hold", rdata, 32'd104);
        bus_read(ADDR_DATA, d);
        check("data_reads_zero", d, 32'd0);

        bus_write(1'b1, ADDR_DIV, 4'b0011, 32'h0000_1234);
        bus_write(1'b1, ADDR_DIV, 4'b0001, 32'hFFFF_FF56);
        bus_read(ADDR_DIV, d);
        check("div_byte_lane", d, 32'h1256);
        bus_write(1'b0, ADDR_DIV, 4'b1111, 32'h0000_0004);
        bus_read(ADDR_DIV, d);
        check("div_sel_gate", d, 32'h1256);

        // Single 0xA5 frame at 4 cycles per bit
        bus_write(1'b1, ADDR_DIV, 4'b0011, 32'd4);
        send(8'hA5, 4);
        poll_status(200, bc, d, to);
        check("a5_timeout", {31'd0, to}, 32'd0);
        check("a5_busy_cycles", bc, 32'd40);
        check("a5_final_status", d, 32'h2);
        check("a5_frames", frames_done, 32'd1);

        // Three back-to-back frames at div 2
        bus_write(1'b1, ADDR_DIV, 4'b0011, 32'd2);
        starts.delete();
        send(8'h01, 2);
        send(8'h02, 2);
        send(8'h03, 2);
        poll_status(300, bc, d, to);
        check("b2b_timeout", {31'd0, to}, 32'd0);
        seq_word = '0;
        foreach (cnt_seq[i]) seq_word = (seq_word << 4) | 32'(cnt_seq[i]);
        check("b2b_count_seq", seq_word, 32'h210);
        check("b2b_nframes", starts.size(), 32'd3);
        check("b2b_gap01", (starts.size() == 3) ? starts[1] - starts[0] : -1, 32'd20);
        check("b2b_gap12", (starts.size() == 3) ? starts[2] - starts[1] : -1, 32'd20);

        // Overflow: fill the FIFO while a frame is in flight, then one more push
        bus_write(1'b1, ADDR_DIV, 4'b0011, 32'd4);
        base = frames_done;
        send(8'h10, 4);
        idle(3);
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 4);
        bus_write(1'b1, ADDR_DATA, 4'b0001, 32'h0000_00EE);
        bus_read(ADDR_STATUS, d);
        check("ovf_status", d, 32'h80D);
        bus_write(1'b1, ADDR_STATUS, 4'b0001, 32'h8);
        bus_read(ADDR_STATUS, d);
        check("ovf_cleared", d, 32'h805);
        poll_status(2000, bc, d, to);
        check("ovf_drain_timeout", {31'd0, to}, 32'd0);
        check("ovf_frames", frames_done - base, 32'd9);
        check("ovf_sb_empty", sb.size(), 32'd0);

        // Divisor 0 behaves as 1
        bus_write(1'b1, ADDR_DIV, 4'b0011, 32'd0);
        send(8'h3C, 1);
        poll_status(100, bc, d, to);
        check("div0_busy_cycles", bc, 32'd10);
        check("div0_final_status", d, 32'h2);

        // Divisor change mid-frame applies to the following frame
        bus_write(1'b1, ADDR_DIV, 4'b0011, 32'd4);
        send(8'h5A, 4);
        send(8'hC3, 8);
        idle(10);
        bus_write(1'b1, ADDR_DIV, 4'b0011, 32'd8);
        poll_status(300, bc, d, to);
        check("middiv_timeout", {31'd0, to}, 32'd0);
        check("middiv_sb_empty", sb.size(), 32'd0);

        // Reset during the data bits of a zero byte
        bus_write(1'b1, ADDR_DIV, 4'b0011, 32'd4);
        send(8'h00, 4);
        send(8'h00, 4);
        send(8'h00, 4);
        idle(8);
        check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
        reset = 1'b0;
        #1;
        check("reset_tx_async", {31'd0, tx}, 32'd1);
        sb.delete();
        base = frames_done;
        idle(2);
        reset = 1'b1;
        idle(1);
        bus_read(ADDR_STATUS, d);
        check("post_reset_status", d, 32'h2);
        bus_read(ADDR_DIV, d);
        check("post_reset_div", d, 32'd104);
        idle(30);
        check("post_reset_no_frames", frames_done - base, 32'd0);

`ifdef MMIO_UART_IRQ_EN
        check("irq_reset", {31'd0, irq}, 32'd0);
        bus_write(1'b1, ADDR_DIV, 4'b0011, 32'd1);
        send(8'h81, 1);
        bus_write(1'b1, ADDR_IE, 4'b0001, 32'd1);
        for (int i = 0; i < 100 && irq_rise_cyc < 0; i++) idle(1);
        check("irq_after_stop", irq_rise_cyc - last_end, 32'd2);
        bus_read(ADDR_IE, d);
        check("ie_readback", d, 32'd1);
`else
        bus_write(1'b1, ADDR_IE, 4'b1111, 32'h3);
        bus_read(ADDR_IE, d);
        check("word3_reads_zero", d, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
